// File: rtl/comp_gt_seq.sv
// comp_gt_seq: sequential magnitude comparator for wide unsigned operands.
//
// Two operands of 4*NIBBLES bits are compared one nibble per cycle, starting
// at the most significant nibble. A single 4-bit greater-than instance and a
// 4-bit equality term are shared across all nibble positions. The compare
// stops at the first nibble that differs.
//
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   synchronous active-high reset
//   start  in   compare request, sampled only while idle
//   a, b   in   unsigned operands, W = 4*NIBBLES bits, latched at accept
//   busy   out  high while nibbles are being evaluated
//   done   out  one-cycle pulse when the result flags become valid
//   gt     out  result A > B
//   eq     out  result A == B
//   lt     out  result A < B
// All outputs are registered.

// 4-bit greater-than primitive shared by every nibble position.
module comp_gt_seq_gt4 (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    output logic       gt_o
);
    assign gt_o = (a_i > b_i);
endmodule

module comp_gt_seq #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    output logic                   busy,
    output logic                   done,
    output logic                   gt,
    output logic                   eq,
    output logic                   lt
);
    localparam int unsigned W  = 4 * NIBBLES;
    // Nibble index width; at least one bit even when NIBBLES == 1.
    localparam int unsigned IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] IDX_MSB = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMP  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic [W-1:0]    ra_q;
    logic [W-1:0]    rb_q;
    logic [IW-1:0]   idx_q;
    logic [IW-1:0]   idx_d;
    logic            busy_q;
    logic            done_q;
    logic            gt_q;
    logic            eq_q;
    logic            lt_q;

    logic [3:0]      nib_a;
    logic [3:0]      nib_b;
    logic            ngt;
    logic            neq;
    logic            nlt;
    logic            idx_zero;

    // Nibble select: explicit mux over legal positions so the index never
    // addresses bits beyond the operand.
    always_comb begin
        nib_a = '0;
        nib_b = '0;
        for (int unsigned i = 0; i < NIBBLES; i++) begin
            if (idx_q == IW'(i)) begin
                nib_a = ra_q[4*i +: 4];
                nib_b = rb_q[4*i +: 4];
            end
        end
    end

    comp_gt_seq_gt4 u_gt4 (
        .a_i  (nib_a),
        .b_i  (nib_b),
        .gt_o (ngt)
    );

    assign neq      = (nib_a == nib_b);
    assign nlt      = ~ngt & ~neq;
    assign idx_zero = (idx_q == '0);
    assign idx_d    = idx_q - IW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            gt_q    <= 1'b0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        ra_q    <= a;
                        rb_q    <= b;
                        idx_q   <= IDX_MSB;
                        gt_q    <= 1'b0;
                        eq_q    <= 1'b0;
                        lt_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_CMP;
                    end
                end
                S_CMP: begin
                    if (ngt) begin
                        gt_q    <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else if (nlt) begin
                        lt_q    <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else if (!idx_zero) begin
                        // Equal nibble with lower nibbles left: step down.
                        idx_q   <= idx_d;
                    end else begin
                        eq_q    <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign gt   = gt_q;
    assign eq   = eq_q;
    assign lt   = lt_q;

endmodule

// File: tb/tb_comp_gt_seq.sv
// Directed bench for comp_gt_seq: a 4-nibble instance and a 1-nibble
// instance share clock and reset. Inputs change 1 time unit after each
// rising edge; outputs are checked at that same point.
module tb_comp_gt_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start4, start1;
    logic [15:0] a4, b4;
    logic [3:0]  a1, b1;
    logic        busy4, done4, gt4, eq4, lt4;
    logic        busy1, done1, gt1, eq1, lt1;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    comp_gt_seq #(.NIBBLES(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .start (start4),
        .a     (a4),
        .b     (b4),
        .busy  (busy4),
        .done  (done4),
        .gt    (gt4),
        .eq    (eq4),
        .lt    (lt4)
    );

    comp_gt_seq #(.NIBBLES(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .busy  (busy1),
        .done  (done1),
        .gt    (gt1),
        .eq    (eq1),
        .lt    (lt1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Packs {busy, done, gt, eq, lt} for compact checks.
    function automatic logic [31:0] st4();
        return {27'd0, busy4, done4, gt4, eq4, lt4};
    endfunction

    function automatic logic [31:0] st1();
        return {27'd0, busy1, done1, gt1, eq1, lt1};
    endfunction

    initial begin
        reset  = 1'b1;
        start4 = 1'b0;
        start1 = 1'b0;
        a4 = '0; b4 = '0; a1 = '0; b1 = '0;
        tick();
        tick();
        chk("reset4", st4(), 32'b00000);
        chk("reset1", st1(), 32'b00000);
        reset = 1'b0;

        // Equal operands: busy for 4 cycles, done after E4 with eq.
        a4 = 16'h1234; b4 = 16'h1234; start4 = 1'b1;
        tick();                      // E0
        start4 = 1'b0;
        chk("eq_E0", st4(), 32'b10000);
        tick(); chk("eq_E1", st4(), 32'b10000);
        tick(); chk("eq_E2", st4(), 32'b10000);
        tick(); chk("eq_E3", st4(), 32'b10000);
        tick(); chk("eq_E4", st4(), 32'b01010);
        tick(); chk("eq_E5", st4(), 32'b00010);

        // MSB decides: gt after E1.
        a4 = 16'h8000; b4 = 16'h7FFF; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        chk("msb_E0", st4(), 32'b10000);
        tick(); chk("msb_E1", st4(), 32'b01100);
        tick(); chk("msb_E2", st4(), 32'b00100);

        // LSB decides: lt after E4, held for 10 idle cycles.
        a4 = 16'h1230; b4 = 16'h1231; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        chk("lsb_E0", st4(), 32'b10000);
        tick(); tick(); tick();
        chk("lsb_E3", st4(), 32'b10000);
        tick(); chk("lsb_E4", st4(), 32'b01001);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("lsb_hold", st4(), 32'b00001);
        end

        // Operand and start isolation.
        a4 = 16'h00F0; b4 = 16'h0F00; start4 = 1'b1;
        tick();                      // E0
        start4 = 1'b0;
        tick();                      // E1: nibble 3 equal
        chk("iso_E1", st4(), 32'b10000);
        a4 = 16'hFFFF; start4 = 1'b1;
        tick();                      // E2: nibble 2 decides lt
        start4 = 1'b0;
        chk("iso_E2", st4(), 32'b01001);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("iso_idle", st4(), 32'b00001);
        end
        start4 = 1'b1;               // a=FFFF, b=0F00 -> gt at MSB
        tick();
        start4 = 1'b0;
        chk("iso2_E0", st4(), 32'b10000);
        tick(); chk("iso2_E1", st4(), 32'b01100);

        // Reset mid-operation.
        tick();
        a4 = 16'hABCD; b4 = 16'hABCD; start4 = 1'b1;
        tick();                      // E0
        start4 = 1'b0;
        tick();                      // E1
        reset = 1'b1;
        tick();                      // E2 with reset
        reset = 1'b0;
        chk("rst_mid", st4(), 32'b00000);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rst_idle", st4(), 32'b00000);
        end
        a4 = 16'hABCD; b4 = 16'hABCC; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        tick(); tick(); tick();
        chk("rst_E3", st4(), 32'b10000);
        tick(); chk("rst_E4", st4(), 32'b01100);

        // NIBBLES=1 instance.
        a1 = 4'h5; b1 = 4'h3; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("n1_gt_E0", st1(), 32'b10000);
        tick(); chk("n1_gt_E1", st1(), 32'b01100);
        tick(); chk("n1_gt_E2", st1(), 32'b00100);
        a1 = 4'h9; b1 = 4'h9; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("n1_eq_E0", st1(), 32'b10000);
        tick(); chk("n1_eq_E1", st1(), 32'b01010);
        tick(); chk("n1_eq_E2", st1(), 32'b00010);

        // Continuous start: accepted every third cycle.
        a1 = 4'h2; b1 = 4'h7; start1 = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (i % 3 == 0)      chk("n1_cont", st1(), 32'b10000);
            else if (i % 3 == 1) chk("n1_cont", st1(), 32'b01001);
            else                 chk("n1_cont", st1(), 32'b00001);
        end
        start1 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/comp_gt_seq.md
# comp_gt_seq

Sequential magnitude comparator controller for wide unsigned operands. It compares two 4*NIBBLES-bit words by stepping one shared 4-bit comparator datapath (a 4-bit greater-than instance plus a 4-bit equality term) across the nibbles, most-significant first. It stops on the first differing nibble. It sits between the pong game logic and the 4-bit comparator primitives, so wide score and position compares reuse one narrow comparator instead of a wide combinational tree.

## Interface
Parameters:
- NIBBLES, 4, number of 4-bit slices per operand; operand width W = 4*NIBBLES; legal range 1..16.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a compare; sampled only in IDLE.
- a  input  W  operand A, unsigned.
- b  input  W  operand B, unsigned.
- busy  output  1  high while in CMP.
- done  output  1  one-cycle pulse when the result becomes valid.
- gt  output  1  result: A > B.
- eq  output  1  result: A == B.
- lt  output  1  result: A < B.

## Operation
- Three-state FSM:
  - IDLE: wait for start.
  - CMP: evaluate one nibble per cycle.
  - DONE: one cycle, done=1.
- IDLE with start=1 at an edge:
  - latch a and b into internal registers ra and rb;
  - set nibble index idx = NIBBLES-1;
  - clear gt, eq and lt;
  - go to CMP.
- IDLE with start=0: stay in IDLE.
- CMP: the datapath sees ra[4*idx+3:4*idx] and rb[4*idx+3:4*idx] combinationally. It produces ngt (A nibble > B nibble), and neq from the equality term. Nibble lt is nlt = ~ngt & ~neq.
  - ngt=1: register gt=1, go to DONE.
  - nlt=1: register lt=1, go to DONE.
  - neq=1 and idx>0: decrement idx, stay in CMP.
  - neq=1 and idx==0: register eq=1, go to DONE.
- DONE: done=1 for this cycle only, then go unconditionally to IDLE.
- Result flags hold after DONE until the next accepted start or reset.
- Exactly one of gt, eq, lt is high from DONE until the next accepted start.
- Operands are latched, so changes on a and b after the start edge do not affect the result.
- start is ignored in CMP and DONE; it is not queued.
- idx is a ceil(log2(NIBBLES)) bit counter, minimum 1 bit. It must never wrap: decrement happens only when idx>0.

## Timing
- Reset values: state=IDLE, busy=0, done=0, gt=0, eq=0, lt=0, idx=0. ra and rb are don't-care.
- reset wins over every other condition at the same edge, including start and mid-CMP. Any compare in progress is abandoned with no done pulse.
- Define the edge sampling start in IDLE as E0.
  - busy is high from E0 until the edge that leaves CMP.
  - The first differing nibble is at position k from the MSB (k = 0..NIBBLES-1). done is high for the cycle after edge E(k+1).
  - Equal operands: done is high after edge E(NIBBLES).
- Worst-case latency, start edge to done: NIBBLES cycles. Best case: 1 cycle.
- Minimum spacing between accepted starts: NIBBLES+2 cycles worst case. A start held high continuously is re-accepted on the first IDLE cycle after DONE.
- Flags update at the same edge that enters DONE, so they are valid together with done.
- Flags clear at the accept edge E0. During CMP, all three flags read 0.
- No combinational path from any input to any output; all outputs are registered.

## Test plan
- Equal operands: NIBBLES=4, a=16'h1234, b=16'h1234, start pulse -> busy high for 4 cycles; done pulse after E4; eq=1, gt=0, lt=0.
- MSB decides: a=16'h8000, b=16'h7FFF -> done after E1 with gt=1, busy high for 1 cycle.
- LSB decides: a=16'h1230, b=16'h1231 -> done after E4 with lt=1; flags stay held in IDLE for 10 cycles afterwards.
- Operand and start isolation:
  - Start with a=16'h00F0, b=16'h0F00.
  - Change to a=16'hFFFF at E1 and pulse start at E2.
  - Expected: lt=1 after E2 (the original operands), and only one done pulse.
  - A second compare begins only on the next IDLE start.
- Reset mid-operation: start with a=b=16'hABCD, assert reset at E2 -> next cycle state IDLE, busy=0, done=0, all flags 0, no done pulse. A fresh start then completes normally.
- Parameter edge: NIBBLES=1.
  - a=4'h5, b=4'h3 -> gt=1 after E1.
  - a=b=4'h9 -> eq=1 after E1.
  - Continuous start=1 -> accepts every 3 cycles; idx never wraps.
